bus_width_split: RTL and testbench

Sequencing controller that carries one wide upstream access (2^IN_P_DW_BYTES bytes) across a narrower downstream port (2^OUT_P_DW_BYTES bytes). It splits the access into aligned narrow beats and skips beats whose byte-enables are all zero. For reads, it reassembles the returned narrow data into the wide lanes. It sits between a core-side wide bus master and a narrow memory/peripheral port, and is the sequential counterpart of the width-alignment datapath.

---
 rtl/bus_width_split_if.sv | 46 ++++
 rtl/bus_width_split.sv | 132 +++++++++++++
 tb/tb_bus_width_split.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_width_split_if.sv
// ============================================================================
// Module   : bus_width_split_if
// Brief    : Upstream wide-access bus plus downstream narrow-beat bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_width_split_if #(
   parameter int IN_P_DW_BYTES  = 3,
   parameter int OUT_P_DW_BYTES = 2,
   parameter int AW             = 32
);
   localparam int IN_DW  = 8 * (2 ** IN_P_DW_BYTES);
   localparam int OUT_DW = 8 * (2 ** OUT_P_DW_BYTES);

   logic                i_req;
   logic                o_req_rdy;
   logic                i_we;
   logic [AW-1:0]       i_addr;
   logic [IN_DW-1:0]    i_wdat;
   logic [IN_DW/8-1:0]  i_be;
   logic                o_resp_vld;
   logic [IN_DW-1:0]    o_rdat;
   logic                o_dn_req;
   logic                i_dn_rdy;
   logic                o_dn_we;
   logic [AW-1:0]       o_dn_addr;
   logic [OUT_DW-1:0]   o_dn_wdat;
   logic [OUT_DW/8-1:0] o_dn_be;
   logic                i_dn_rvld;
   logic [OUT_DW-1:0]   i_dn_rdat;

   modport slave (
      input  i_req, i_we, i_addr, i_wdat, i_be, i_dn_rdy, i_dn_rvld, i_dn_rdat,
      output o_req_rdy, o_resp_vld, o_rdat, o_dn_req, o_dn_we, o_dn_addr,
             o_dn_wdat, o_dn_be
   );

   modport master (
      output i_req, i_we, i_addr, i_wdat, i_be, i_dn_rdy, i_dn_rvld, i_dn_rdat,
      input  o_req_rdy, o_resp_vld, o_rdat, o_dn_req, o_dn_we, o_dn_addr,
             o_dn_wdat, o_dn_be
   );
endinterface

`default_nettype wire

// File: rtl/bus_width_split.sv
// ============================================================================
// Module   : bus_width_split
// Brief    : Splits one wide access into aligned narrow beats, skipping empty
//            beats and reassembling read data into the wide lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_width_split #(
   parameter int IN_P_DW_BYTES  = 3,
   parameter int OUT_P_DW_BYTES = 2,
   parameter int AW             = 32
) (
   input  wire              clk,
   input  wire              rst_n,
   bus_width_split_if.slave bus
);
   localparam int KW     = IN_P_DW_BYTES - OUT_P_DW_BYTES;
   localparam int NBEATS = 2 ** KW;
   localparam int IN_DW  = 8 * (2 ** IN_P_DW_BYTES);
   localparam int OUT_DW = 8 * (2 ** OUT_P_DW_BYTES);
   localparam int OBY    = OUT_DW / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   generate
      if (OUT_P_DW_BYTES >= IN_P_DW_BYTES) begin : g_bad_cfg
         $error("bus_width_split: OUT_P_DW_BYTES must be < IN_P_DW_BYTES");
      end
   endgenerate

   logic [1:0]                r_state;
   logic                      r_we;
   logic [AW-1:IN_P_DW_BYTES] r_addr_hi;
   logic [IN_DW-1:0]          r_wdat;
   logic [IN_DW/8-1:0]        r_be;
   logic [KW-1:0]             r_k;
   logic [IN_DW-1:0]          r_rdat;

   logic [NBEATS-1:0]         w_in_nz;
   logic [NBEATS-1:0]         w_cur_nz;
   logic [OUT_DW-1:0]         w_wdat_beat [NBEATS];
   logic [OBY-1:0]            w_be_beat   [NBEATS];
   logic [KW:0]               w_first;
   logic [KW:0]               w_next;
   logic                      w_unused;

   genvar gb;
   generate
      for (gb = 0; gb < NBEATS; gb++) begin : g_beat
         assign w_in_nz[gb]     = |bus.i_be[gb*OBY +: OBY];
         assign w_cur_nz[gb]    = |r_be[gb*OBY +: OBY];
         assign w_wdat_beat[gb] = r_wdat[gb*OUT_DW +: OUT_DW];
         assign w_be_beat[gb]   = r_be[gb*OBY +: OBY];
      end
   endgenerate

   // Returns {found, index} of the lowest non-empty beat strictly above 'above'.
   function automatic logic [KW:0] f_find(input logic [NBEATS-1:0] nz, input int above);
      logic [KW:0] res;
      res = '0;
      for (int b = NBEATS - 1; b >= 0; b--) begin
         if (nz[b] && (b > above)) res = {1'b1, KW'(b)};
      end
      return res;
   endfunction

   assign w_first  = f_find(w_in_nz, -1);
   assign w_next   = f_find(w_cur_nz, int'(r_k));
   assign w_unused = ^bus.i_addr[IN_P_DW_BYTES-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_we      <= 1'b0;
         r_addr_hi <= '0;
         r_wdat    <= '0;
         r_be      <= '0;
         r_k       <= '0;
         r_rdat    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_req) begin
                  r_we      <= bus.i_we;
                  r_addr_hi <= bus.i_addr[AW-1:IN_P_DW_BYTES];
                  r_wdat    <= bus.i_wdat;
                  r_be      <= bus.i_be;
                  r_rdat    <= '0;
                  r_k       <= w_first[KW-1:0];
                  r_state   <= w_first[KW] ? S_ISSUE : S_RESP;
               end
            end
            S_ISSUE: begin
               if (bus.i_dn_rdy) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus.i_dn_rvld) begin
                  if (!r_we) begin
                     for (int b = 0; b < NBEATS; b++) begin
                        if (r_k == KW'(b)) r_rdat[b*OUT_DW +: OUT_DW] <= bus.i_dn_rdat;
                     end
                  end
                  if (w_next[KW]) begin
                     r_k     <= w_next[KW-1:0];
                     r_state <= S_ISSUE;
                  end else begin
                     r_state <= S_RESP;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Beat fields come straight from latched state so they hold during stalls.
   assign bus.o_req_rdy  = (r_state == S_IDLE);
   assign bus.o_resp_vld = (r_state == S_RESP);
   assign bus.o_rdat     = r_rdat;
   assign bus.o_dn_req   = (r_state == S_ISSUE);
   assign bus.o_dn_we    = r_we;
   assign bus.o_dn_addr  = {r_addr_hi, r_k, {OUT_P_DW_BYTES{1'b0}}};
   assign bus.o_dn_wdat  = w_wdat_beat[r_k];
   assign bus.o_dn_be    = w_be_beat[r_k];

endmodule

`default_nettype wire

// File: tb/tb_bus_width_split.sv
// ============================================================================
// Module   : tb_bus_width_split
// Brief    : Directed self-checking bench for bus_width_split (8B -> 4B).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_width_split;
   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   bus_width_split_if #(.IN_P_DW_BYTES(3), .OUT_P_DW_BYTES(2), .AW(32)) bus ();

   bus_width_split #(.IN_P_DW_BYTES(3), .OUT_P_DW_BYTES(2), .AW(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one access and plays a downstream responder; rvld follows acceptance by one cycle.
   task automatic run_access(
      input  logic        we,
      input  logic [31:0] addr,
      input  logic [63:0] wdat,
      input  logic [7:0]  be,
      input  int          stall,
      input  logic        spur,
      input  logic [31:0] d0,
      input  logic [31:0] d1,
      output int          cyc,
      output int          nb,
      output logic [31:0] a0,
      output logic [31:0] a1,
      output logic [31:0] w0,
      output logic [3:0]  b0,
      output logic [3:0]  b1,
      output logic [63:0] rd,
      output logic        held_ok
   );
      int          st;
      logic        pend;
      logic        new_beat;
      logic        pk;
      logic [31:0] ha;
      logic [31:0] hw;
      logic [3:0]  hb;
      st = 0; pend = 1'b0; new_beat = 1'b1; pk = 1'b0;
      nb = 0; a0 = '0; a1 = '0; w0 = '0; b0 = '0; b1 = '0; held_ok = 1'b1;
      ha = '0; hw = '0; hb = '0;
      bus.i_req = 1'b1; bus.i_we = we; bus.i_addr = addr; bus.i_wdat = wdat; bus.i_be = be;
      bus.i_dn_rdy = 1'b0; bus.i_dn_rvld = 1'b0;
      tick();
      bus.i_req = 1'b0;
      cyc = 1;
      while (!bus.o_resp_vld && cyc < 60) begin
         bus.i_dn_rvld = 1'b0;
         bus.i_dn_rdy  = 1'b0;
         if (bus.o_dn_req) begin
            if (new_beat) begin
               ha = bus.o_dn_addr; hw = bus.o_dn_wdat; hb = bus.o_dn_be;
               new_beat = 1'b0;
            end else if (bus.o_dn_addr !== ha || bus.o_dn_wdat !== hw || bus.o_dn_be !== hb) begin
               held_ok = 1'b0;
            end
            if (spur) begin
               bus.i_dn_rvld = 1'b1;
               bus.i_dn_rdat = 32'hDEADBEEF;
            end
            if (nb == 0 && st < stall) begin
               st++;
               bus.i_we   = ~bus.i_we;
               bus.i_addr = $urandom;
               bus.i_wdat = {$urandom, $urandom};
               bus.i_be   = 8'($urandom);
            end else begin
               bus.i_dn_rdy = 1'b1;
               if (nb == 0) begin a0 = ha; w0 = hw; b0 = hb; end
               else begin a1 = ha; b1 = hb; end
               pk = ha[2];
               nb++;
               pend = 1'b1;
               new_beat = 1'b1;
            end
         end else if (pend) begin
            bus.i_dn_rvld = 1'b1;
            bus.i_dn_rdat = pk ? d1 : d0;
            pend = 1'b0;
         end
         tick();
         cyc++;
      end
      bus.i_dn_rvld = 1'b0;
      bus.i_dn_rdy  = 1'b0;
      rd = bus.o_rdat;
   endtask

   int          cyc;
   int          nb;
   logic [31:0] a0;
   logic [31:0] a1;
   logic [31:0] w0;
   logic [3:0]  b0;
   logic [3:0]  b1;
   logic [63:0] rd;
   logic        held;

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0;
      bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_wdat = '0; bus.i_be = '0;
      bus.i_dn_rdy = 1'b0; bus.i_dn_rvld = 1'b0; bus.i_dn_rdat = '0;
      tick(); tick();
      chk("rst_req_rdy",  64'(bus.o_req_rdy),  64'd1);
      chk("rst_resp_vld", 64'(bus.o_resp_vld), 64'd0);
      chk("rst_dn_req",   64'(bus.o_dn_req),   64'd0);
      chk("rst_rdat",     bus.o_rdat,          64'd0);
      chk("rst_dn_addr",  64'(bus.o_dn_addr),  64'd0);
      rst_n = 1'b1;
      tick();

      run_access(1'b0, 32'h1004, 64'h0, 8'hFF, 0, 1'b0, 32'h11111111, 32'h22222222,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("rd2_cycles", 64'(cyc), 64'd5);
      chk("rd2_beats",  64'(nb),  64'd2);
      chk("rd2_addr0",  64'(a0),  64'h1000);
      chk("rd2_addr1",  64'(a1),  64'h1004);
      chk("rd2_be0",    64'(b0),  64'hF);
      chk("rd2_be1",    64'(b1),  64'hF);
      chk("rd2_rdat",   rd,       64'h22222222_11111111);
      chk("rd2_rdy_in_resp", 64'(bus.o_req_rdy), 64'd0);
      tick();
      chk("rd2_rdy_after", 64'(bus.o_req_rdy),  64'd1);
      chk("rd2_resp_pulse", 64'(bus.o_resp_vld), 64'd0);

      // Spurious completion in IDLE must not disturb the held read data.
      bus.i_dn_rvld = 1'b1; bus.i_dn_rdat = 32'hCAFEF00D;
      tick();
      bus.i_dn_rvld = 1'b0;
      chk("spur_idle_rdat", bus.o_rdat, 64'h22222222_11111111);
      chk("spur_idle_rdy",  64'(bus.o_req_rdy), 64'd1);

      run_access(1'b1, 32'h2000, 64'hAABBCCDD_01020304, 8'hF0, 0, 1'b0, 32'h0, 32'h0,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("wr_cycles", 64'(cyc), 64'd3);
      chk("wr_beats",  64'(nb),  64'd1);
      chk("wr_addr",   64'(a0),  64'h2004);
      chk("wr_wdat",   64'(w0),  64'hAABBCCDD);
      chk("wr_be",     64'(b0),  64'hF);
      chk("wr_rdat",   rd,       64'd0);
      tick();

      run_access(1'b0, 32'h3000, 64'h0, 8'h00, 0, 1'b0, 32'h1, 32'h2,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("be0_cycles", 64'(cyc), 64'd1);
      chk("be0_beats",  64'(nb),  64'd0);
      chk("be0_rdat",   rd,       64'd0);
      tick();

      run_access(1'b0, 32'h1000, 64'h0, 8'hFF, 3, 1'b0, 32'h0BADF00D, 32'h12345678,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("stall_cycles", 64'(cyc),  64'd8);
      chk("stall_held",   64'(held), 64'd1);
      chk("stall_addr0",  64'(a0),   64'h1000);
      chk("stall_rdat",   rd,        64'h12345678_0BADF00D);
      tick();

      run_access(1'b0, 32'h4000, 64'h0, 8'h30, 0, 1'b1, 32'h99999999, 32'h76543210,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("part_cycles", 64'(cyc), 64'd3);
      chk("part_addr",   64'(a0),  64'h4004);
      chk("part_be",     64'(b0),  64'h3);
      chk("part_rdat",   rd,       64'h76543210_00000000);
      tick();

      // Reset while waiting on beat 1 of a read.
      bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 32'h3000;
      bus.i_wdat = 64'hFFFFFFFF_FFFFFFFF; bus.i_be = 8'hFF; bus.i_dn_rdy = 1'b1;
      tick();
      bus.i_req = 1'b0;
      tick();
      bus.i_dn_rvld = 1'b1; bus.i_dn_rdat = 32'h5555AAAA;
      tick();
      bus.i_dn_rvld = 1'b0;
      tick();
      chk("mid_rdat",    bus.o_rdat,         64'h00000000_5555AAAA);
      chk("mid_dn_addr", 64'(bus.o_dn_addr), 64'h3004);
      bus.i_dn_rdy = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_req_rdy", 64'(bus.o_req_rdy),  64'd1);
      chk("arst_rdat",    bus.o_rdat,          64'd0);
      chk("arst_dn_addr", 64'(bus.o_dn_addr),  64'd0);
      chk("arst_dn_wdat", 64'(bus.o_dn_wdat),  64'd0);
      chk("arst_dn_be",   64'(bus.o_dn_be),    64'd0);
      chk("arst_dn_req",  64'({bus.o_dn_req, bus.o_resp_vld, bus.o_dn_we}), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();

      run_access(1'b0, 32'h5008, 64'h0, 8'hFF, 0, 1'b0, 32'h01234567, 32'h89ABCDEF,
                 cyc, nb, a0, a1, w0, b0, b1, rd, held);
      chk("post_cycles", 64'(cyc), 64'd5);
      chk("post_addr0",  64'(a0),  64'h5008);
      chk("post_rdat",   rd,       64'h89ABCDEF_01234567);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

`default_nettype wire
